instr_fetch_decode: RTL and testbench

INSTR_FETCH_DECODE -- requirements
Module: instr_fetch_decode

---
 rtl/instr_fetch_decode_pkg.sv | 41 ++++
 rtl/instr_fetch_decode_if.sv | 24 ++
 rtl/instr_field_decoder.sv | 23 ++
 rtl/instr_fetch_decode.sv | 103 ++++++++++
 tb/tb_instr_fetch_decode.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_decode_pkg.sv
// rtl/instr_fetch_decode_pkg.sv - shared opcode, state and field-layout definitions
package instr_fetch_decode_pkg;

  localparam int ADDR_W_DEF  = 5;
  localparam int INSTR_W_DEF = 23;

  // Instruction word layout: rs and imm deliberately overlap.
  localparam int OPC_MSB = 22;
  localparam int OPC_LSB = 19;
  localparam int RD_MSB  = 18;
  localparam int RD_LSB  = 16;
  localparam int RS_MSB  = 15;
  localparam int RS_LSB  = 13;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  typedef enum logic [3:0] {
    OP_HALT = 4'd0,
    OP_LOAD = 4'd1,
    OP_MOV  = 4'd2,
    OP_ADD  = 4'd3,
    OP_SUB  = 4'd4,
    OP_XOR  = 4'd5,
    OP_OR   = 4'd6,
    OP_AND  = 4'd7,
    OP_DIV  = 4'd8,
    OP_MOD  = 4'd9
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  function automatic logic op_is_illegal(input logic [3:0] op);
    return op > 4'(OP_MOD);
  endfunction

endpackage

// File: rtl/instr_fetch_decode_if.sv
// rtl/instr_fetch_decode_if.sv - decoded-instruction handshake bus toward the execute stage
interface instr_fetch_decode_if #(
  parameter int ADDR_W = 5
);
  logic              dec_valid;
  logic              dec_ready;
  logic [3:0]        dec_opcode;
  logic [2:0]        dec_rd;
  logic [2:0]        dec_rs;
  logic [15:0]       dec_imm;
  logic [2:0]        dec_sw;
  logic [ADDR_W-1:0] dec_pc;
  logic              dec_illegal;

  modport master (
    output dec_valid, dec_opcode, dec_rd, dec_rs, dec_imm, dec_sw, dec_pc, dec_illegal,
    input  dec_ready
  );

  modport slave (
    input  dec_valid, dec_opcode, dec_rd, dec_rs, dec_imm, dec_sw, dec_pc, dec_illegal,
    output dec_ready
  );
endinterface

// File: rtl/instr_field_decoder.sv
// rtl/instr_field_decoder.sv - combinational field split and legality check of a ROM word
module instr_field_decoder
  import instr_fetch_decode_pkg::*;
#(
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic [INSTR_W-1:0] code,
  output logic [3:0]         opcode,
  output logic [2:0]         rd,
  output logic [2:0]         rs,
  output logic [15:0]        imm,
  output logic               is_halt,
  output logic               is_illegal
);

  assign opcode     = code[OPC_MSB:OPC_LSB];
  assign rd         = code[RD_MSB:RD_LSB];
  assign rs         = code[RS_MSB:RS_LSB];
  assign imm        = code[IMM_MSB:IMM_LSB];
  assign is_halt    = (opcode == 4'(OP_HALT));
  assign is_illegal = op_is_illegal(opcode);

endmodule

// File: rtl/instr_fetch_decode.sv
// rtl/instr_fetch_decode.sv - fetch/issue FSM, program counter and decoded-instruction registers
module instr_fetch_decode
  import instr_fetch_decode_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [ADDR_W-1:0]     rom_addr,
  input  logic [INSTR_W-1:0]    rom_code,
  input  logic [2:0]            rom_sw,
  instr_fetch_decode_if.master  dec,
  output logic                  busy,
  output logic                  halted
);

  state_e            state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic              load;

  logic [3:0]  f_opcode;
  logic [2:0]  f_rd, f_rs;
  logic [15:0] f_imm;
  logic        f_halt, f_illegal;

  instr_field_decoder #(.INSTR_W(INSTR_W)) u_dec (
    .code       (rom_code),
    .opcode     (f_opcode),
    .rd         (f_rd),
    .rs         (f_rs),
    .imm        (f_imm),
    .is_halt    (f_halt),
    .is_illegal (f_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      pc    <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    load      = 1'b0;
    case (state)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          pc_nxt    = '0;
          state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        load      = 1'b1;
        state_nxt = f_halt ? ST_HALT : ST_ISSUE;
      end
      ST_ISSUE: begin
        // The last ROM address ends the program instead of wrapping to 0.
        if (dec.dec_ready) begin
          if (dec.dec_illegal || (pc == {ADDR_W{1'b1}})) begin
            state_nxt = ST_HALT;
          end else begin
            pc_nxt    = pc + ADDR_W'(1);
            state_nxt = ST_FETCH;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec.dec_opcode  <= '0;
      dec.dec_rd      <= '0;
      dec.dec_rs      <= '0;
      dec.dec_imm     <= '0;
      dec.dec_sw      <= '0;
      dec.dec_pc      <= '0;
      dec.dec_illegal <= 1'b0;
    end else if (load) begin
      dec.dec_opcode  <= f_opcode;
      dec.dec_rd      <= f_rd;
      dec.dec_rs      <= f_rs;
      dec.dec_imm     <= f_imm;
      dec.dec_sw      <= rom_sw;
      dec.dec_pc      <= pc;
      dec.dec_illegal <= f_illegal;
    end
  end

  assign dec.dec_valid = (state == ST_ISSUE);
  assign busy          = (state == ST_FETCH) || (state == ST_ISSUE);
  assign halted        = (state == ST_HALT);
  assign rom_addr      = pc;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// tb/tb_instr_fetch_decode.sv - randomized self-checking bench for instr_fetch_decode
module tb_instr_fetch_decode;

  localparam int AW = 5;
  localparam int IW = 23;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [IW-1:0] rom_code;
  logic [2:0]    rom_sw;
  logic          busy, halted;

  logic [IW-1:0] rom [32];
  logic [2:0]    swm [32];

  int checks = 0;
  int errors = 0;

  logic [34:0] exp_q[$];
  int          exp_end;

  instr_fetch_decode_if #(.ADDR_W(AW)) dec_bus ();

  instr_fetch_decode #(.ADDR_W(AW), .INSTR_W(IW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .rom_addr (rom_addr),
    .rom_code (rom_code),
    .rom_sw   (rom_sw),
    .dec      (dec_bus.master),
    .busy     (busy),
    .halted   (halted)
  );

  assign rom_code = rom[rom_addr];
  assign rom_sw   = swm[rom_addr];

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [34:0] dut_item();
    return {dec_bus.dec_pc, dec_bus.dec_opcode, dec_bus.dec_rd, dec_bus.dec_rs,
            dec_bus.dec_imm, dec_bus.dec_sw, dec_bus.dec_illegal};
  endfunction

  // Reference: walk the program as the execute stage would see it.
  task automatic model();
    int pc;
    int unsigned w, op, rd, rs, imm, sw;
    exp_q.delete();
    pc = 0;
    exp_end = 0;
    for (int n = 0; n < 40; n++) begin
      w   = int'(rom[pc]);
      sw  = int'(swm[pc]);
      op  = (w >> 19) % 16;
      rd  = (w >> 16) % 8;
      rs  = (w >> 13) % 8;
      imm = w % 65536;
      exp_end = pc;
      if (op == 0) return;
      exp_q.push_back({5'(pc), 4'(op), 3'(rd), 3'(rs), 16'(imm), 3'(sw), 1'(op >= 10)});
      if (op >= 10 || pc == 31) return;
      pc++;
    end
  endtask

  function automatic logic [IW-1:0] legal_word();
    return {4'(1 + $urandom % 9), 19'($urandom)};
  endfunction

  task automatic fill_legal(input int n);
    for (int i = 0; i < 32; i++) begin
      rom[i] = (i < n) ? legal_word() : '0;
      swm[i] = 3'($urandom);
    end
  endtask

  // rmode: 0 ready always high, 1 random ready, 2 hold ready low 5 cycles at pc 9
  task automatic run_prog(input int rmode, input bit rand_start);
    int  cyc, hold;
    bit  done;
    model();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc  = 1;
    hold = 0;
    done = 1'b0;
    while (!done && cyc < 300) begin
      if (cyc == 1) begin
        check("lat_fetch_valid", dec_bus.dec_valid, 1'b0);
        check("lat_fetch_busy", busy, 1'b1);
      end
      if (cyc == 2 && exp_q.size() > 0) check("lat_issue_valid", dec_bus.dec_valid, 1'b1);
      case (rmode)
        0: dec_bus.dec_ready = 1'b1;
        1: dec_bus.dec_ready = 1'($urandom % 2);
        default: begin
          if (dec_bus.dec_valid && dec_bus.dec_pc == 5'd9 && hold < 5) begin
            dec_bus.dec_ready = 1'b0;
            hold++;
          end else begin
            dec_bus.dec_ready = 1'b1;
          end
        end
      endcase
      if (dec_bus.dec_valid) begin
        if (exp_q.size() == 0) begin
          check("extra_issue", 1, 0);
        end else begin
          check("issue_fields", dut_item(), exp_q[0]);
          check("issue_rom_addr", rom_addr, exp_q[0][34:30]);
          if (dec_bus.dec_ready) void'(exp_q.pop_front());
        end
      end
      start = 1'b0;
      if (halted) done = 1'b1;
      else if (rand_start && busy && ($urandom % 4 == 0)) start = 1'b1;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("run_timeout", done, 1'b1);
    check("issues_remaining", exp_q.size(), 0);
    check("end_halted", halted, 1'b1);
    check("end_busy", busy, 1'b0);
    check("end_valid", dec_bus.dec_valid, 1'b0);
    check("end_rom_addr", rom_addr, exp_end);
    if (rmode == 2) check("hold_cycles", hold, 5);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, dec_bus.dec_valid, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_halted"}, halted, 1'b0);
    check({tag, "_rom_addr"}, rom_addr, 0);
    check({tag, "_fields"}, dut_item(), 35'd0);
  endtask

  initial begin
    bit hit;
    dec_bus.dec_ready = 1'b0;
    fill_legal(18);
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_state("idle_wait");

    // First word LOAD R0 #0x000C, then 18-word program ending at an all-zero word
    rom[0] = 23'h08000C;
    swm[0] = 3'd0;
    run_prog(0, 1'b0);
    run_prog(1, 1'b1);

    // MOV R5 R7 at address 9 with a 5-cycle stall
    fill_legal(18);
    rom[9] = {4'd2, 3'd5, 3'd7, 13'($urandom)};
    run_prog(2, 1'b0);

    // Illegal opcode 0xC at address 3, then restart from 0
    fill_legal(18);
    rom[3] = {4'hC, 19'($urandom)};
    run_prog(1, 1'b1);
    run_prog(0, 1'b0);

    // Every address legal: stops at 31 without wrapping
    fill_legal(32);
    run_prog(0, 1'b0);
    run_prog(1, 1'b1);

    // Random programs with occasional HALT and illegal words
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 32; i++) begin
        case ($urandom % 12)
          0:       rom[i] = {4'd0, 19'($urandom)};
          1:       rom[i] = {4'(10 + $urandom % 6), 19'($urandom)};
          default: rom[i] = legal_word();
        endcase
        swm[i] = 3'($urandom);
      end
      run_prog(1, 1'b1);
    end

    // Reset asserted while pc 6 is being issued
    fill_legal(32);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dec_bus.dec_ready = 1'b1;
    hit = 1'b0;
    for (int c = 0; c < 60 && !hit; c++) begin
      if (dec_bus.dec_valid && dec_bus.dec_pc == 5'd6) begin
        hit = 1'b1;
        rst_n = 1'b0;
        #1;
        check_reset_state("mid_issue_reset");
      end else begin
        @(negedge clk);
      end
    end
    check("reached_pc6", hit, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_state("post_reset_idle");
    run_prog(1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
